// File: rtl/alu_exec_unit.sv
// ALU execution unit with ready/valid handshake: single-cycle ADD/SUB/AND/ORR/LSL/LSR
// and an iterative shift-add multiplier that takes DATA_WIDTH cycles.
module alu_exec_unit #(
    parameter int DATA_WIDTH  = 64,
    parameter int INSTR_WIDTH = 11,
    parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             ALUOp,
    input  logic [INSTR_WIDTH-1:0] instruction,
    input  logic [DATA_WIDTH-1:0]  a,
    input  logic [DATA_WIDTH-1:0]  b,
    input  logic [SHAMT_WIDTH-1:0] shamt,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  result,
    output logic [3:0]             operation,
    output logic                   zero,
    output logic                   negative,
    output logic                   carry,
    output logic                   overflow,
    output logic                   illegal,
    output logic                   busy
);

    localparam int MSB = DATA_WIDTH - 1;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_ORR = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_LSL = 4'b1001;
    localparam logic [3:0] OP_LSR = 4'b1010;

    localparam logic [INSTR_WIDTH-1:0] I_ADD = INSTR_WIDTH'(11'b10001011000);
    localparam logic [INSTR_WIDTH-1:0] I_SUB = INSTR_WIDTH'(11'b11001011000);
    localparam logic [INSTR_WIDTH-1:0] I_AND = INSTR_WIDTH'(11'b10001010000);
    localparam logic [INSTR_WIDTH-1:0] I_ORR = INSTR_WIDTH'(11'b10101010000);
    localparam logic [INSTR_WIDTH-1:0] I_MUL = INSTR_WIDTH'(11'b10011011000);
    localparam logic [INSTR_WIDTH-1:0] I_LSL = INSTR_WIDTH'(11'b11010011011);
    localparam logic [INSTR_WIDTH-1:0] I_LSR = INSTR_WIDTH'(11'b11010011010);

    localparam logic [SHAMT_WIDTH-1:0] LAST_ITER = SHAMT_WIDTH'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;

    state_t                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  result_q, result_d;
    logic [3:0]             operation_q, operation_d;
    logic                   zero_q, zero_d;
    logic                   negative_q, negative_d;
    logic                   carry_q, carry_d;
    logic                   overflow_q, overflow_d;
    logic                   illegal_q, illegal_d;
    logic [DATA_WIDTH-1:0]  mcand_q, mcand_d;
    logic [DATA_WIDTH-1:0]  mplier_q, mplier_d;
    logic [DATA_WIDTH-1:0]  acc_q, acc_d;
    logic [SHAMT_WIDTH-1:0] count_q, count_d;

    logic [3:0]            opDec;
    logic                  illegalDec;
    logic [DATA_WIDTH-1:0] aluRes;
    logic                  aluCarry;
    logic                  aluOvf;
    logic [DATA_WIDTH:0]   addFull;
    logic [DATA_WIDTH:0]   subFull;
    logic [DATA_WIDTH-1:0] accSum;

    assign addFull = {1'b0, a} + {1'b0, b};
    assign subFull = {1'b0, a} + {1'b0, ~b} + {{DATA_WIDTH{1'b0}}, 1'b1};
    assign accSum  = acc_q + (mplier_q[0] ? mcand_q : '0);

    // Unknown R-type opcodes still execute as ADD but are tagged illegal.
    always_comb begin
        opDec      = OP_ADD;
        illegalDec = 1'b0;
        case (ALUOp)
            2'b00: opDec = OP_ADD;
            2'b10: begin
                case (instruction)
                    I_ADD:   opDec = OP_ADD;
                    I_SUB:   opDec = OP_SUB;
                    I_AND:   opDec = OP_AND;
                    I_ORR:   opDec = OP_ORR;
                    I_MUL:   opDec = OP_MUL;
                    I_LSL:   opDec = OP_LSL;
                    I_LSR:   opDec = OP_LSR;
                    default: illegalDec = 1'b1;
                endcase
            end
            default: opDec = OP_SUB;
        endcase
    end

    always_comb begin
        aluRes   = '0;
        aluCarry = 1'b0;
        aluOvf   = 1'b0;
        case (opDec)
            OP_ADD: begin
                {aluCarry, aluRes} = addFull;
                aluOvf = (a[MSB] == b[MSB]) && (addFull[MSB] != a[MSB]);
            end
            OP_SUB: begin
                {aluCarry, aluRes} = subFull;
                aluOvf = (a[MSB] != b[MSB]) && (subFull[MSB] != a[MSB]);
            end
            OP_AND:  aluRes = a & b;
            OP_ORR:  aluRes = a | b;
            OP_LSL:  aluRes = a << shamt;
            OP_LSR:  aluRes = a >> shamt;
            default: aluRes = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        operation_d = operation_q;
        zero_d      = zero_q;
        negative_d  = negative_q;
        carry_d     = carry_q;
        overflow_d  = overflow_q;
        illegal_d   = illegal_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        count_d     = count_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (opDec == OP_MUL) begin
                        mcand_d  = a;
                        mplier_d = b;
                        acc_d    = '0;
                        count_d  = '0;
                        state_d  = MUL;
                    end else begin
                        result_d    = aluRes;
                        operation_d = opDec;
                        zero_d      = (aluRes == '0);
                        negative_d  = aluRes[MSB];
                        carry_d     = aluCarry;
                        overflow_d  = aluOvf;
                        illegal_d   = illegalDec;
                        state_d     = HOLD;
                    end
                end
            end
            MUL: begin
                acc_d    = accSum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + 1'b1;
                // Bits shifted past DATA_WIDTH are dropped, so the product wraps.
                if (count_q == LAST_ITER) begin
                    result_d    = accSum;
                    operation_d = OP_MUL;
                    zero_d      = (accSum == '0);
                    negative_d  = accSum[MSB];
                    carry_d     = 1'b0;
                    overflow_d  = 1'b0;
                    illegal_d   = 1'b0;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            result_q    <= '0;
            operation_q <= '0;
            zero_q      <= 1'b0;
            negative_q  <= 1'b0;
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
            illegal_q   <= 1'b0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            operation_q <= operation_d;
            zero_q      <= zero_d;
            negative_q  <= negative_d;
            carry_q     <= carry_d;
            overflow_q  <= overflow_d;
            illegal_q   <= illegal_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == MUL);
    assign out_valid = (state_q == HOLD);
    assign result    = result_q;
    assign operation = operation_q;
    assign zero      = zero_q;
    assign negative  = negative_q;
    assign carry     = carry_q;
    assign overflow  = overflow_q;
    assign illegal   = illegal_q;

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter DATA_WIDTH, 64, operand/result width (power of two, >=8).
REQ-002 Parameter INSTR_WIDTH, 11, R-type opcode field width.
REQ-003 Parameter SHAMT_WIDTH, $clog2(DATA_WIDTH), shift-amount width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  request present.
REQ-007 in_ready  output  1  unit can accept request.
REQ-008 ALUOp  input  2  main-control ALU opcode.
REQ-009 instruction  input  INSTR_WIDTH  R-type opcode field.
REQ-010 a, b  input  DATA_WIDTH each  operands.
REQ-011 shamt  input  SHAMT_WIDTH  shift amount (LSL/LSR).
REQ-012 out_valid  output  1  result valid.
REQ-013 out_ready  input  1  consumer takes result.
REQ-014 result  output  DATA_WIDTH  registered result.
REQ-015 operation  output  4  registered decoded operation code.
REQ-016 zero, negative, carry, overflow  output  1 each  registered flags.
REQ-017 illegal  output  1  registered: opcode not in decode table.
REQ-018 busy  output  1  high while multiply iterates.

Function
REQ-019 Decode SHALL be: ALUOp=00 -> ADD 0010; ALUOp[0]=1 (01, 11) -> SUB 0110; ALUOp=10 -> by instruction.
REQ-020 R-type table SHALL be: 10001011000 ADD 0010; 11001011000 SUB 0110; 10001010000 AND 0000; 10101010000 ORR 0001; 10011011000 MUL 1000; 11010011011 LSL 1001; 11010011010 LSR 1010 (INSTR_WIDTH=11).
REQ-021 Unlisted opcode with ALUOp=10 SHALL execute ADD, operation=0010, illegal=1.
REQ-022 FSM states SHALL be IDLE, MUL, HOLD; in_ready=1 only in IDLE; busy=1 only in MUL.
REQ-023 IDLE, in_valid=1, non-MUL op: result/flags/operation/illegal registered same edge, go HOLD; out_valid=1 from the next cycle (latency 1).
REQ-024 IDLE, in_valid=1, MUL: load multiplicand=a, multiplier=b, acc=0, count=0, go MUL.
REQ-025 MUL each cycle: if multiplier[0] acc+=multiplicand; multiplicand<<=1; multiplier>>=1; count++; on DATA_WIDTH-th iteration register result=low DATA_WIDTH bits of product, go HOLD (out_valid high DATA_WIDTH cycles after accepting edge).
REQ-026 HOLD: out_valid=1, result/flags/operation/illegal stable; out_ready=1 -> IDLE, out_valid=0 next cycle.
REQ-027 in_valid SHALL be ignored outside IDLE; operand inputs sampled only on the accepting edge.
REQ-028 ADD: {carry,result}=a+b; overflow= a,b same sign and result sign differs.
REQ-029 SUB: {carry,result}=a+~b+1 (carry=1 means no borrow); overflow= a,b differ in sign and result sign differs from a.
REQ-030 AND/ORR/MUL/LSL/LSR: carry=0, overflow=0; LSL=a<<shamt, LSR=a>>shamt (logical, zero fill); shamt=0 passes a.
REQ-031 zero=(result==0); negative=result[DATA_WIDTH-1], all ops.
REQ-032 MUL overflow beyond DATA_WIDTH bits SHALL be discarded silently.
REQ-033 Maximum throughput SHALL be one request per two cycles (no accept in HOLD).

Reset
REQ-034 rst=1 at a rising edge SHALL force IDLE and clear result, operation, flags, illegal, out_valid, busy, and multiplier datapath to 0.
REQ-035 Reset in MUL or HOLD SHALL abort the operation; no out_valid for it; in_ready=1 the cycle after rst deasserts.
REQ-036 in_valid during a rst cycle SHALL not be accepted.

Verification
REQ-037 ALUOp=10, instr=10001011000, a=0x7FFF_FFFF_FFFF_FFFF, b=1, out_ready=1 -> next cycle out_valid=1, result=0x8000_0000_0000_0000, negative=1, overflow=1, carry=0, operation=0010.
REQ-038 ALUOp=01, a=5, b=5 -> result=0, zero=1, carry=1, operation=0110; repeat ALUOp=11 -> identical.
REQ-039 ALUOp=10, instr=10011011000, a=12, b=13 -> busy for 64 cycles, out_valid at 64th cycle after accept, result=156; out_ready held 0 for 5 cycles -> result stable, in_ready=0.
REQ-040 ALUOp=10, instr=11010011011, a=1, shamt=63 -> result=0x8000_0000_0000_0000; instr=11010011010, a=0x8000_0000_0000_0000, shamt=63 -> result=1.
REQ-041 ALUOp=10, instr=11111111111, a=2, b=3 -> result=5, illegal=1, operation=0010.
REQ-042 Start MUL, assert rst at cycle 20 -> out_valid never rises, all outputs 0, in_ready=1 cycle after rst drops; new ADD 1+1 -> result=2.
